// File: rtl/sq_pkg.sv
// Shared definitions for the square accumulator: FSM state encoding and
// the width of one nibble square.
package sq_pkg;

    localparam int SQ_W = 8;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/nibble_square_lut.sv
// Combinational square of a 4-bit magnitude (0..15 -> 0..225) as a
// constant table.
module nibble_square_lut
    import sq_pkg::*;
(
    input  logic [3:0]      n,
    output logic [SQ_W-1:0] sq
);

    always_comb begin
        sq = '0;
        case (n)
            4'd0:  sq = 8'd0;
            4'd1:  sq = 8'd1;
            4'd2:  sq = 8'd4;
            4'd3:  sq = 8'd9;
            4'd4:  sq = 8'd16;
            4'd5:  sq = 8'd25;
            4'd6:  sq = 8'd36;
            4'd7:  sq = 8'd49;
            4'd8:  sq = 8'd64;
            4'd9:  sq = 8'd81;
            4'd10: sq = 8'd100;
            4'd11: sq = 8'd121;
            4'd12: sq = 8'd144;
            4'd13: sq = 8'd169;
            4'd14: sq = 8'd196;
            4'd15: sq = 8'd225;
            default: sq = '0;
        endcase
    end

endmodule

// File: rtl/square_accumulator.sv
// Frame-based sum of squares of signed nibble samples with saturation,
// valid/ready on both sides and a held result until the consumer takes it.
module square_accumulator
    import sq_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_n,
    input  logic             in_sign,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_sat
);

    localparam logic [ACC_W-1:0] SUM_MAX = {ACC_W{1'b1}};
    localparam logic [7:0]       LEN     = 8'(FRAME_LEN);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [7:0]       out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;

    logic [SQ_W-1:0]  sq;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_next;
    logic [7:0]       cnt_next;
    logic             sat_next;
    logic             accept;
    logic             frame_end;

    // The square is sign-independent, so the sign bit is deliberately unused.
    logic unused_sign;
    assign unused_sign = in_sign;

    nibble_square_lut u_lut (
        .n  (in_n),
        .sq (sq)
    );

    // One extra carry bit detects overflow past the sum width.
    always_comb begin
        sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - SQ_W){1'b0}}, sq};
        sat_next  = sat_q | sum_ext[ACC_W];
        acc_next  = sum_ext[ACC_W] ? SUM_MAX : sum_ext[ACC_W-1:0];
        cnt_next  = cnt_q + 8'd1;
        accept    = in_valid && (state_q == ST_ACCUM);
        frame_end = accept && ((cnt_next == LEN) || in_last);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            ST_ACCUM: begin
                if (frame_end) begin
                    out_sum_d   = acc_next;
                    out_count_d = cnt_next;
                    out_sat_d   = sat_next;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sat_d       = 1'b0;
                    state_d     = ST_HOLD;
                end else if (accept) begin
                    acc_d = acc_next;
                    cnt_d = cnt_next;
                    sat_d = sat_next;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_square_accumulator.sv
// Directed bench for square_accumulator: a 16/12 instance for most
// scenarios and an ACC_W=8 instance for saturation.
module tb_square_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_sign, a_in_last;
    logic [3:0]  a_in_n;
    logic        a_out_valid, a_out_ready, a_out_sat;
    logic [11:0] a_out_sum;
    logic [7:0]  a_out_count;

    logic        b_in_valid, b_in_ready, b_in_sign, b_in_last;
    logic [3:0]  b_in_n;
    logic        b_out_valid, b_out_ready, b_out_sat;
    logic [7:0]  b_out_sum;
    logic [7:0]  b_out_count;

    int checks = 0;
    int errors = 0;

    square_accumulator #(.FRAME_LEN(16), .ACC_W(12)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_n(a_in_n),
        .in_sign(a_in_sign), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_count(a_out_count), .out_sat(a_out_sat)
    );

    square_accumulator #(.FRAME_LEN(16), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_n(b_in_n),
        .in_sign(b_in_sign), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_count(b_out_count), .out_sat(b_out_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] n, input logic sgn, input logic last);
        a_in_valid = 1'b1;
        a_in_n     = n;
        a_in_sign  = sgn;
        a_in_last  = last;
        tick();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        a_in_sign  = 1'b0;
    endtask

    task automatic take_a();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_sum !== 12'd0 || a_out_count !== 8'd0 || a_out_sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: valid=%b sum=%0d count=%0d sat=%b expected 0 0 0 0",
                     a_out_valid, a_out_sum, a_out_count, a_out_sat);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: a=%b b=%b expected 1 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 16; i++) begin
            send_a(4'(i), 1'b0, 1'b0);
            if (i == 14) begin
                checks++;
                if (a_out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_early_valid: out_valid=%b expected 0", a_out_valid);
                end
            end
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_valid: out_valid=%b in_ready=%b expected 1 0", a_out_valid, a_in_ready);
        end
        checks++;
        if (a_out_sum !== 12'd1240 || a_out_count !== 8'd16 || a_out_sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_result: sum=%0d count=%0d sat=%b expected 1240 16 0",
                     a_out_sum, a_out_count, a_out_sat);
        end
        take_a();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_release: out_valid=%b in_ready=%b expected 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_in_last();
        send_a(4'd3, 1'b1, 1'b0);
        send_a(4'd4, 1'b0, 1'b0);
        send_a(4'd5, 1'b0, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 12'd50 || a_out_count !== 8'd3 || a_out_sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL last_result: valid=%b sum=%0d count=%0d sat=%b expected 1 50 3 0",
                     a_out_valid, a_out_sum, a_out_count, a_out_sat);
        end
        take_a();
    endtask

    task automatic test_saturation();
        b_in_valid = 1'b1;
        b_in_n     = 4'd15;
        b_in_last  = 1'b0;
        tick();
        b_in_last  = 1'b1;
        tick();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_sum !== 8'd255 || b_out_sat !== 1'b1 || b_out_count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL sat_result: valid=%b sum=%0d sat=%b count=%0d expected 1 255 1 2",
                     b_out_valid, b_out_sum, b_out_sat, b_out_count);
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_release: out_valid=%b in_ready=%b expected 0 1", b_out_valid, b_in_ready);
        end
    endtask

    task automatic test_hold();
        send_a(4'd2, 1'b0, 1'b0);
        send_a(4'd2, 1'b0, 1'b1);
        a_in_valid = 1'b1;
        a_in_n     = 4'd15;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_sum !== 12'd8 ||
                a_out_count !== 8'd2 || a_out_sat !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_stable[%0d]: ready=%b valid=%b sum=%0d count=%0d sat=%b expected 0 1 8 2 0",
                         i, a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_sat);
            end
        end
        a_in_valid = 1'b0;
        take_a();
        send_a(4'd1, 1'b0, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 12'd1 || a_out_count !== 8'd1 || a_out_sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_next_clean: valid=%b sum=%0d count=%0d sat=%b expected 1 1 1 0",
                     a_out_valid, a_out_sum, a_out_count, a_out_sat);
        end
        take_a();
    endtask

    task automatic test_mid_reset();
        int seen_valid = 0;
        for (int i = 0; i < 7; i++) begin
            send_a(4'd3, 1'b0, 1'b0);
            if (a_out_valid !== 1'b0) seen_valid++;
        end
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        tick();
        if (a_out_valid !== 1'b0) seen_valid++;
        checks++;
        if (seen_valid != 0) begin
            errors++;
            $display("[TB] FAIL reset_no_valid: cycles with out_valid=%0d expected 0", seen_valid);
        end
        for (int i = 0; i < 16; i++) send_a(4'd1, 1'b0, 1'b0);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 12'd16 || a_out_count !== 8'd16) begin
            errors++;
            $display("[TB] FAIL reset_next_frame: valid=%b sum=%0d count=%0d expected 1 16 16",
                     a_out_valid, a_out_sum, a_out_count);
        end
        take_a();
    endtask

    task automatic test_last_on_boundary();
        int extra = 0;
        for (int i = 0; i < 16; i++) send_a(4'd2, 1'b0, (i == 15) ? 1'b1 : 1'b0);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 12'd64 || a_out_count !== 8'd16) begin
            errors++;
            $display("[TB] FAIL boundary_result: valid=%b sum=%0d count=%0d expected 1 64 16",
                     a_out_valid, a_out_sum, a_out_count);
        end
        take_a();
        for (int i = 0; i < 4; i++) begin
            if (a_out_valid !== 1'b0) extra++;
            tick();
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL boundary_single: extra result cycles=%0d expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        send_a(4'd7, 1'b1, 1'b1);
        take_a();
        send_a(4'd6, 1'b0, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 12'd36 || a_out_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL back_to_back: valid=%b sum=%0d count=%0d expected 1 36 1",
                     a_out_valid, a_out_sum, a_out_count);
        end
        take_a();
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_n = 4'd0; a_in_sign = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_n = 4'd0; b_in_sign = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;
        rst = 1'b1;
        test_reset();
        test_full_frame();
        test_in_last();
        test_saturation();
        test_hold();
        test_mid_reset();
        test_last_on_boundary();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_accumulator.md
SQUARE_ACCUMULATOR -- requirements
Module: square_accumulator

Interface
REQ-001 Parameter FRAME_LEN, default 16, SHALL set the samples per frame (legal range 1..255).
REQ-002 Parameter ACC_W, default 12, SHALL set the sum width in bits (minimum 8).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL flag a sample present on in_n/in_sign.
REQ-006 in_ready  output  1  SHALL flag that the block accepts a sample this cycle.
REQ-007 in_n  input  4  SHALL carry the sample magnitude, 0..15.
REQ-008 in_sign  input  1  SHALL carry the sample sign (1 = negative).
REQ-009 in_last  input  1  SHALL, when accepted with a sample, end the frame early.
REQ-010 out_valid  output  1  SHALL flag that a frame result is held on the out_* ports.
REQ-011 out_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-012 out_sum  output  ACC_W  SHALL carry the frame sum of squares.
REQ-013 out_count  output  8  SHALL carry the number of samples in the frame.
REQ-014 out_sat  output  1  SHALL flag that the sum saturated during the frame.

Function
REQ-015 A sample SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-016 The square of each sample SHALL be in_n*in_n, exact, 0..225 (15 -> 225).
REQ-017 in_sign SHALL NOT affect the square.
REQ-018 The state machine SHALL have two states.
- ACCUM: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-019 In ACCUM, each accepted sample SHALL add its square to the accumulator and increment the sample count by 1.
REQ-020 The frame SHALL end on the accepted sample that makes count equal FRAME_LEN, or on an accepted sample with in_last=1, whichever comes first.
REQ-021 On frame end, the final sum/count/sat (final sample included) SHALL be registered to the out_* ports and the state SHALL become HOLD; out_valid SHALL rise the cycle after the final accept.
REQ-022 In HOLD, the out_* ports SHALL stay stable until out_ready=1.
REQ-023 On that out_ready=1 cycle the state SHALL return to ACCUM with accumulator, count and sat cleared, so in_ready=1 the next cycle.
REQ-024 Sample acceptance in HOLD is not permitted; samples presented in HOLD SHALL be ignored.
REQ-025 Accumulation SHALL saturate at 2^ACC_W-1; once saturated, the sum SHALL stay at that value and sat SHALL be 1 for the rest of the frame.
REQ-026 A frame of a single sample (FRAME_LEN=1, or in_last on the first sample) SHALL produce out_count=1.
REQ-027 in_last asserted on the FRAME_LEN-th sample SHALL end exactly one frame, not two.
REQ-028 Throughput SHALL be one sample per cycle in ACCUM; one result per frame.

Reset
REQ-029 While rst=1, the block SHALL hold these values.
- State ACCUM.
- in_ready=1 after reset release.
- out_valid=0.
- out_sum=0, out_count=0, out_sat=0.
- Accumulator, count and sat cleared.
REQ-030 rst asserted mid-frame or in HOLD SHALL discard the partial or held result with no output handshake.

Structure
REQ-031 State encoding and the squares table width constant (SQ_W=8) SHALL live in the shared package sq_pkg.
REQ-032 The squaring SHALL be one combinational sub-module, nibble_square_lut, with a 4-bit input and SQ_W-bit output; all sequential logic stays in square_accumulator.

Verification
REQ-033 The bench SHALL cover these directed scenarios, with FRAME_LEN=16 and ACC_W=12 unless stated.
- Samples n=0..15 with out_ready=1 -> out_sum=1240, out_count=16, out_sat=0; out_valid one cycle after the 16th accept.
- Samples n=3 (sign=1), 4, then 5 with in_last -> out_sum=50, out_count=3.
- ACC_W=8, samples 15, 15 with in_last -> out_sum=255, out_sat=1.
- Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_* stable, no sample counted; next frame starts clean.
- rst pulsed after 7 samples -> out_valid=0 throughout; a following frame of sixteen n=1 samples gives out_sum=16.
- in_last on the 16th sample -> exactly one result, out_count=16.
